writeback: RTL and testbench
============================

# writeback

Writeback stage of the RV32 pipeline and the producer side of the decode stage's register-file write port (`write_enable`, `write_addr`, `write_data`). It merges two result streams into that single port: ALU results, which arrive every cycle with no backpressure, and load results, which arrive from the data-memory side through a valid/ready handshake. Load data is sign- or zero-extended here, and results are buffered so that no result is lost when both streams want the port in the same cycle.

## Interface
Parameters:
- `WORD_SIZE`, 32: data width.
- `LQ_DEPTH`, 4: load-queue entries; must be a power of two, minimum 2.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_write_enable` in 1: ALU result writes a register.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in WORD_SIZE: ALU result.
- `load_valid` in 1: load result offered.
- `load_ready` out 1: load result can be accepted.
- `load_rd` in 5: load destination register.
- `load_funct3` in 3: load width/sign.
- `load_offset` in 2: byte address bits [1:0].
- `load_data` in WORD_SIZE: raw aligned memory word.
- `write_enable` out 1: register-file write strobe.
- `write_addr` out 5: register-file write address.
- `write_data` out WORD_SIZE: register-file write data.
- `lq_count` out $clog2(LQ_DEPTH)+1: load-queue occupancy.

## Operation
- An ALU write request is `alu_valid && alu_write_enable`. It always wins the write port.
- A load is accepted when `load_valid && load_ready`. `load_ready` is `!full` and does not depend on `load_valid`.
  - At acceptance, the load is extended and stored in the load queue as (rd, data).
- In a cycle with no ALU write request and a non-empty queue, the head entry is popped and drives the port.
- Load extension, with the byte lane selected by `load_offset`:
  - LB 000: sign-extend byte `load_offset`.
  - LH 001: sign-extend half `load_offset[1]`.
  - LW 010: whole word.
  - LBU 100: zero-extend byte `load_offset`.
  - LHU 101: zero-extend half `load_offset[1]`.
  - Codes 011, 110 and 111 are treated as LW.
  - `load_offset[0]` is ignored for halfwords.
- Writes to x0 use the port slot (a queue entry is still popped), but `write_enable` stays 0.
- Simultaneous push and pop is allowed, and `lq_count` is unchanged in that case.
- When the queue is full, `load_ready` is 0 even if a pop happens in the same cycle. There is no same-cycle pass-through.
- The queue pointers wrap modulo `LQ_DEPTH`. Order is strictly FIFO among loads.
- Asserting `reset` mid-operation flushes the queue and discards any pending results.

## Timing
- Reset values: `write_enable`=0, `write_addr`=0, `write_data`=0, `lq_count`=0, `load_ready`=0.
  - `load_ready` is 0 while `reset` is high and goes to 1 in the first cycle after release.
- `write_*` outputs are registered. An ALU request in cycle t appears on the port in t+1.
- A load accepted in t is poppable in t+1 at the earliest, so it appears on the port in t+2 at the earliest.
- Each cycle in which an ALU write request is present delays queue drain by one cycle.
- `lq_count` is registered and reflects the push/pop of the previous cycle.

## Configuration
- `WB_FORWARD_EN` defined:
  - Adds outputs `fwd_valid` (1), `fwd_addr` (5) and `fwd_data` (WORD_SIZE).
  - These combinationally expose the selected write of the current cycle, i.e. the next-state values of `write_*`, so that decode can bypass.
  - `fwd_valid` is 0 for x0 and while `reset` is high.
- Not defined: these ports and their logic are absent. Port behaviour is otherwise identical.

## Structure
- Package `wb_pkg`:
  - Load funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - `REG_ADDR_W`=5.
  - Typedef `lq_entry_t` {rd, data}.
  - The extension function.
- Sub-module `load_queue`: synchronous FIFO of `lq_entry_t` with push, pop, full, empty and count. All other logic is in `writeback`.

## Test plan
- Reset, then ALU x5=0x1234 in cycle 1 → `write_enable`=1, `write_addr`=5, `write_data`=0x1234 in cycle 2. All outputs are 0 during reset.
- LB, offset 2, data 0x0080_0000, rd 7 → writes 0xFFFF_FF80. LBU → 0x0000_0080. LH, offset 2, data 0x8001_0000 → 0xFFFF_8001.
- ALU write requests every cycle for 6 cycles while loads are offered every cycle → `load_ready` falls after 4 acceptances. Then the 4 loads drain in order on consecutive cycles, with no loss.
- Queue full and a pop in the same cycle → `load_ready` is still 0 that cycle and 1 in the next cycle. `lq_count` follows 4→3.
- Load and ALU both targeting x0 → `write_enable` never goes to 1, and the queue still drains.
- `reset` asserted with 3 queued loads → no writes appear afterwards, and `lq_count`=0. With `WB_FORWARD_EN` defined, `fwd_*` matches `write_*` one cycle early.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback stage:
//   - load funct3 encodings (F3_LB .. F3_LHU)
//   - register address width and native data width
//   - lq_entry_t : one load-queue entry {rd, data}
//   - extend_load(): selects the byte/half lane of an aligned memory word and
//     sign- or zero-extends it according to funct3
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lq_entry_t;

    // Unused funct3 codes fall through to the whole-word case. For halfwords
    // only offset[1] picks the lane; offset[0] is deliberately ignored.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [2:0]      funct3,
        input logic [1:0]      offset,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        byte_lane = word[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   extend_load = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   extend_load = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  extend_load = {24'b0, byte_lane};
            F3_LHU:  extend_load = {16'b0, half_lane};
            default: extend_load = word;
        endcase
    endfunction

endpackage

// File: rtl/load_queue.sv
// -----------------------------------------------------------------------------
// load_queue
// Synchronous FIFO of lq_entry_t holding extended load results until the
// register-file write port is free.
// Ports:
//   clock, reset      : clock, synchronous active-high flush
//   push, push_entry  : write an entry (ignored when full)
//   pop               : discard the head entry (ignored when empty)
//   head              : current head entry, valid whenever !empty
//   full, empty       : status, derived from the registered occupancy
//   count             : registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module load_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  lq_entry_t              push_entry,
    input  logic                   pop,
    output lq_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    lq_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;

    // Head is read asynchronously so the writeback stage can pop it into its
    // registered write port in the same cycle; the port register is the
    // effective read register.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
// RV32 writeback stage: merges ALU results (every cycle, no backpressure) and
// load results (valid/ready) onto the single register-file write port.
// ALU requests always win; loads wait in load_queue and drain when the port
// is free. Writes to x0 consume the port slot but keep write_enable low.
// Ports:
//   clock, reset                         : clock, synchronous active-high
//   alu_valid/alu_write_enable/alu_rd/alu_data : ALU result stream
//   load_valid/load_ready/load_rd/load_funct3/load_offset/load_data
//                                        : load result handshake
//   write_enable/write_addr/write_data   : registered register-file port
//   lq_count                             : registered load-queue occupancy
// Optional feature, macro WB_FORWARD_EN:
//   fwd_valid/fwd_addr/fwd_data expose the next-state write_* values
//   combinationally for decode bypass.
// WORD_SIZE must match wb_pkg::XLEN.
// -----------------------------------------------------------------------------
module writeback
    import wb_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int LQ_DEPTH  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alu_valid,
    input  logic                      alu_write_enable,
    input  logic [REG_ADDR_W-1:0]     alu_rd,
    input  logic [WORD_SIZE-1:0]      alu_data,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [REG_ADDR_W-1:0]     load_rd,
    input  logic [2:0]                load_funct3,
    input  logic [1:0]                load_offset,
    input  logic [WORD_SIZE-1:0]      load_data,
    output logic                      write_enable,
    output logic [REG_ADDR_W-1:0]     write_addr,
    output logic [WORD_SIZE-1:0]      write_data,
    output logic [$clog2(LQ_DEPTH):0] lq_count
`ifdef WB_FORWARD_EN
    ,
    output logic                      fwd_valid,
    output logic [REG_ADDR_W-1:0]     fwd_addr,
    output logic [WORD_SIZE-1:0]      fwd_data
`endif
);

    logic                  alu_req;
    logic                  lq_push;
    logic                  lq_pop;
    logic                  lq_full;
    logic                  lq_empty;
    lq_entry_t             lq_in;
    lq_entry_t             lq_head;

    logic                  write_enable_reg, write_enable_next;
    logic [REG_ADDR_W-1:0] write_addr_reg,   write_addr_next;
    logic [WORD_SIZE-1:0]  write_data_reg,   write_data_next;

    assign alu_req    = alu_valid && alu_write_enable;
    // Ready looks only at the registered occupancy, so a pop in the same
    // cycle does not reopen a full queue until the next cycle.
    assign load_ready = !lq_full && !reset;
    assign lq_push    = load_valid && load_ready;
    assign lq_pop     = !alu_req && !lq_empty;

    assign lq_in.rd   = load_rd;
    assign lq_in.data = extend_load(load_funct3, load_offset, load_data);

    load_queue #(
        .DEPTH (LQ_DEPTH)
    ) u_load_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (lq_push),
        .push_entry (lq_in),
        .pop        (lq_pop),
        .head       (lq_head),
        .full       (lq_full),
        .empty      (lq_empty),
        .count      (lq_count)
    );

    // Port arbitration. Address/data hold their value on idle cycles so the
    // bus only toggles when a result actually moves.
    always_comb begin
        write_enable_next = 1'b0;
        write_addr_next   = write_addr_reg;
        write_data_next   = write_data_reg;
        if (alu_req) begin
            write_enable_next = (alu_rd != '0);
            write_addr_next   = alu_rd;
            write_data_next   = alu_data;
        end else if (!lq_empty) begin
            write_enable_next = (lq_head.rd != '0);
            write_addr_next   = lq_head.rd;
            write_data_next   = lq_head.data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_enable_reg <= 1'b0;
            write_addr_reg   <= '0;
            write_data_reg   <= '0;
        end else begin
            write_enable_reg <= write_enable_next;
            write_addr_reg   <= write_addr_next;
            write_data_reg   <= write_data_next;
        end
    end

    assign write_enable = write_enable_reg;
    assign write_addr   = write_addr_reg;
    assign write_data   = write_data_reg;

`ifdef WB_FORWARD_EN
    assign fwd_valid = write_enable_next && !reset;
    assign fwd_addr  = write_addr_next;
    assign fwd_data  = write_data_next;
`endif

endmodule

// File: tb/tb_writeback.sv
// -----------------------------------------------------------------------------
// tb_writeback
// Directed bench for writeback: reset state, ALU path, load extension,
// ALU-blocked queue fill and ordered drain, full+pop ready behaviour, x0
// handling and mid-operation reset. Forwarding outputs are checked when
// WB_FORWARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_writeback;
    import wb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_write_enable = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [4:0]  load_rd = '0;
    logic [2:0]  load_funct3 = '0;
    logic [1:0]  load_offset = '0;
    logic [31:0] load_data = '0;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [2:0]  lq_count;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;
    int k;

    writeback #(
        .WORD_SIZE (32),
        .LQ_DEPTH  (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .alu_valid        (alu_valid),
        .alu_write_enable (alu_write_enable),
        .alu_rd           (alu_rd),
        .alu_data         (alu_data),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_rd          (load_rd),
        .load_funct3      (load_funct3),
        .load_offset      (load_offset),
        .load_data        (load_data),
        .write_enable     (write_enable),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .lq_count         (lq_count)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid        (fwd_valid),
        .fwd_addr         (fwd_addr),
        .fwd_data         (fwd_data)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        if (obs === exp) $display("check %-18s value=0x%08h", tag, obs);
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, "_we"},   32'(write_enable), 32'(we));
        check({tag, "_addr"}, 32'(write_addr),   32'(addr));
        check({tag, "_data"}, write_data,        data);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        alu_valid        = 1'b0;
        alu_write_enable = 1'b0;
        alu_rd           = '0;
        alu_data         = '0;
        load_valid       = 1'b0;
        load_rd          = '0;
        load_funct3      = '0;
        load_offset      = '0;
        load_data        = '0;
    endtask

    // One isolated load: accepted at the first edge, written at the second.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] d, input logic [31:0] exp);
        load_valid  = 1'b1;
        load_rd     = rd;
        load_funct3 = f3;
        load_offset = off;
        load_data   = d;
        tick;
        load_valid  = 1'b0;
        check({tag, "_count1"}, 32'(lq_count), 32'd1);
        check({tag, "_early"},  32'(write_enable), 32'd0);
        tick;
        check_wr(tag, 1'b1, rd, exp);
        check({tag, "_count0"}, 32'(lq_count), 32'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick;
        tick;
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst_count", 32'(lq_count), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
`ifdef WB_FORWARD_EN
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
`endif
        reset = 1'b0;
        #1;
        check("rel_ready", 32'(load_ready), 32'd1);

        // ---------------- ALU write, one cycle latency ----------------
        alu_valid = 1'b1; alu_write_enable = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
`ifdef WB_FORWARD_EN
        check("fwd_alu_valid", 32'(fwd_valid), 32'd1);
        check("fwd_alu_addr",  32'(fwd_addr),  32'd5);
        check("fwd_alu_data",  fwd_data,       32'h1234);
`endif
        tick;
        clear_inputs;
        check_wr("alu_x5", 1'b1, 5'd5, 32'h1234);
        tick;
        check("alu_idle_we", 32'(write_enable), 32'd0);

        // ---------------- load extension ----------------
        do_load("lb",   5'd7, F3_LB,  2'd2, 32'h0080_0000, 32'hFFFF_FF80);
        do_load("lbu",  5'd7, F3_LBU, 2'd2, 32'h0080_0000, 32'h0000_0080);
        do_load("lh",   5'd8, F3_LH,  2'd2, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu3", 5'd9, F3_LHU, 2'd3, 32'h8001_0000, 32'h0000_8001);
        do_load("lb0",  5'd6, F3_LB,  2'd0, 32'h1234_567F, 32'h0000_007F);
        do_load("lw",   5'd4, F3_LW,  2'd0, 32'h8765_4321, 32'h8765_4321);
        do_load("f3_7", 5'd3, 3'b111, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        tick;

        // ---------------- ALU every cycle while loads are offered ----------------
        k = 0;
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_write_enable = 1'b1;
            alu_rd = 5'(20 + i); alu_data = 32'hA000 + 32'(i);
            load_valid = 1'b1; load_rd = 5'(10 + k); load_funct3 = F3_LW;
            load_offset = 2'd0; load_data = 32'hB000 + 32'(k);
            check("burst_ready", 32'(load_ready), 32'(i < 4));
            if (i < 4) k++;
            tick;
            check_wr("burst_alu", 1'b1, 5'(20 + i), 32'hA000 + 32'(i));
            check("burst_count", 32'(lq_count), (i < 4) ? 32'(i + 1) : 32'd4);
        end

        // Full queue popping this cycle: still not ready; offer rd 14.
        alu_valid = 1'b0; alu_write_enable = 1'b0;
        load_rd = 5'd14; load_data = 32'hB004;
        #1;
        check("full_pop_ready", 32'(load_ready), 32'd0);
`ifdef WB_FORWARD_EN
        check("fwd_head_addr", 32'(fwd_addr), 32'd10);
`endif
        tick;
        check_wr("drain0", 1'b1, 5'd10, 32'hB000);
        check("drain0_count", 32'(lq_count), 32'd3);
        check("reopen_ready", 32'(load_ready), 32'd1);
        // Push rd 14 while popping rd 11: occupancy holds.
        tick;
        load_valid = 1'b0;
        check_wr("drain1", 1'b1, 5'd11, 32'hB001);
        check("pushpop_count", 32'(lq_count), 32'd3);
        for (int j = 2; j < 5; j++) begin
            tick;
            check_wr("drain", 1'b1, 5'(10 + j), 32'hB000 + 32'(j));
            check("drain_count", 32'(lq_count), 32'(4 - j));
        end
        tick;
        check("drained_we", 32'(write_enable), 32'd0);

        // ---------------- x0 targets ----------------
        alu_valid = 1'b1; alu_write_enable = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        load_valid = 1'b1; load_rd = 5'd0; load_funct3 = F3_LW; load_data = 32'h1111;
        #1;
`ifdef WB_FORWARD_EN
        check("fwd_x0_valid", 32'(fwd_valid), 32'd0);
`endif
        tick;
        clear_inputs;
        check("x0_alu_we", 32'(write_enable), 32'd0);
        check("x0_count1", 32'(lq_count), 32'd1);
        tick;
        check("x0_load_we", 32'(write_enable), 32'd0);
        check("x0_count0", 32'(lq_count), 32'd0);
        tick;
        check("x0_idle_we", 32'(write_enable), 32'd0);

        // ---------------- reset with 3 queued loads ----------------
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_write_enable = 1'b1; alu_rd = 5'd0;
            load_valid = 1'b1; load_rd = 5'(3 + i); load_funct3 = F3_LW;
            load_data = 32'hC000 + 32'(i);
            tick;
        end
        clear_inputs;
        check("pre_rst_count", 32'(lq_count), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(load_ready), 32'd0);
        tick;
        check("mid_rst_count", 32'(lq_count), 32'd0);
        check("mid_rst_we", 32'(write_enable), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("post_rst_we", 32'(write_enable), 32'd0);
            check("post_rst_count", 32'(lq_count), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
